// File: rtl/baby_kyber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : baby_kyber_pkg
// Description : Shared ring parameters, widths, FSM state type and polynomial
//               container types for the Baby Kyber decryption core.
// Revision    : 1.0 - initial release
// ============================================================================
package baby_kyber_pkg;

    localparam int COEFF_W = 32;    // signed coefficient width on ports
    localparam int Q       = 17;    // modulus
    localparam int N       = 4;     // coefficients per polynomial
    localparam int K       = 2;     // polynomials per vector
    localparam int ACC_W   = 16;    // signed accumulator width
    localparam int RED_W   = 5;     // width of a value in 0..Q-1
    localparam int DEC_LO  = 5;     // lowest coefficient decoding to 1
    localparam int DEC_HI  = 12;    // highest coefficient decoding to 1

    // MAC counter decomposes as {k, i, j}; N and K are powers of two.
    localparam int IDX_W    = $clog2(N);
    localparam int KIDX_W   = (K > 1) ? $clog2(K) : 1;
    localparam int CNT_W    = 2 * IDX_W + KIDX_W;
    localparam int MAC_LAST = K * N * N - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef coeff_t [N-1:0]            poly_t;
    typedef poly_t  [K-1:0]            polyvec_t;
    typedef logic [RED_W-1:0]          red_t;

endpackage : baby_kyber_pkg
`default_nettype wire

// File: rtl/baby_kyber_decrypt_mod_q_reduce.sv
`default_nettype none
// ============================================================================
// Module      : mod_q_reduce
// Description : Combinational floor-mod of a signed value into 0..Q-1.
//               Negative inputs map to their positive residue (-8 -> 9).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_q_reduce
    import baby_kyber_pkg::*;
#(
    parameter int IN_W = COEFF_W
)
(
    input  logic signed [IN_W-1:0]  i_x,
    output logic        [RED_W-1:0] o_r
);

    localparam logic signed [IN_W-1:0] c_Q = IN_W'(Q);

    logic signed [IN_W-1:0] w_rem;
    logic signed [IN_W-1:0] w_pos;

    // Truncating remainder, then lift negative remainders into 0..Q-1.
    always_comb begin
        w_rem = i_x % c_Q;
        w_pos = w_rem;
        if (w_rem[IN_W-1]) begin
            w_pos = w_rem + c_Q;
        end
        o_r = RED_W'(w_pos);
    end

endmodule : mod_q_reduce
`default_nettype wire

// File: rtl/baby_kyber_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : baby_kyber_decrypt
// Description : Multi-cycle Baby Kyber decryption. Computes m' = v - s^T.u in
//               Z_Q[x]/(x^N+1) with one coefficient product per cycle, then
//               decodes each coefficient of m' to one message bit.
// Revision    : 1.0 - initial release
// ============================================================================
module baby_kyber_decrypt
    import baby_kyber_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  polyvec_t       ct_u,
    input  poly_t          ct_v,
    input  polyvec_t       sk_s,
    output logic           out_valid,
    input  logic           out_ready,
    output poly_t          m_coeff,
    output logic [N-1:0]   m_bits
);

    localparam logic [CNT_W-1:0] c_MAC_LAST = CNT_W'(MAC_LAST);

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_capture;

    // Operands reduced at capture time
    red_t                      w_s_red [K][N];
    red_t                      w_u_red [K][N];
    red_t                      w_v_red [N];
    red_t                      r_s     [K][N];
    red_t                      r_u     [K][N];
    red_t                      r_v     [N];

    logic signed [ACC_W-1:0]   r_acc   [N];
    logic [CNT_W-1:0]          r_cnt;

    // Counter decode: j fastest, then i, then k
    logic [IDX_W-1:0]          w_j;
    logic [IDX_W-1:0]          w_i;
    logic [KIDX_W-1:0]         w_k;
    logic [IDX_W:0]            w_sum;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_wrap;
    logic [2*RED_W-1:0]        w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;

    // Final reduction
    logic signed [COEFF_W-1:0] w_diff  [N];
    red_t                      w_m_red [N];
    poly_t                     r_m_coeff;
    logic [N-1:0]              r_m_bits;

    // ------------------------------------------------------------------------
    // Operand and result reducers
    // ------------------------------------------------------------------------
    for (genvar gk = 0; gk < K; gk++) begin : g_vec
        for (genvar gi = 0; gi < N; gi++) begin : g_coef
            mod_q_reduce #(.IN_W(COEFF_W)) u_red_s (
                .i_x (sk_s[gk][gi]),
                .o_r (w_s_red[gk][gi])
            );
            mod_q_reduce #(.IN_W(COEFF_W)) u_red_u (
                .i_x (ct_u[gk][gi]),
                .o_r (w_u_red[gk][gi])
            );
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_poly
        mod_q_reduce #(.IN_W(COEFF_W)) u_red_v (
            .i_x (ct_v[gj]),
            .o_r (w_v_red[gj])
        );

        assign w_diff[gj] = {{(COEFF_W-RED_W){1'b0}}, r_v[gj]}
                          - {{(COEFF_W-ACC_W){r_acc[gj][ACC_W-1]}}, r_acc[gj]};

        mod_q_reduce #(.IN_W(COEFF_W)) u_red_m (
            .i_x (w_diff[gj]),
            .o_r (w_m_red[gj])
        );
    end

    // ------------------------------------------------------------------------
    // Shared multiplier and negacyclic target index
    // ------------------------------------------------------------------------
    assign w_j        = r_cnt[IDX_W-1:0];
    assign w_i        = r_cnt[2*IDX_W-1:IDX_W];
    assign w_k        = r_cnt[CNT_W-1:2*IDX_W];
    assign w_sum      = {1'b0, w_i} + {1'b0, w_j};
    // N is a power of two, so i+j-N is just the low bits of i+j
    assign w_idx      = w_sum[IDX_W-1:0];
    assign w_wrap     = w_sum[IDX_W];
    assign w_prod     = {{RED_W{1'b0}}, r_s[w_k][w_i]} * {{RED_W{1'b0}}, r_u[w_k][w_j]};
    assign w_prod_ext = $signed({{(ACC_W-2*RED_W){1'b0}}, w_prod});

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake decode from the state register
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_MAC;
                end
            end
            S_MAC: begin
                if (r_cnt == c_MAC_LAST) begin
                    w_next = S_REDUCE;
                end
            end
            S_REDUCE: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, multiply-accumulate, final reduce/decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s       <= '{default: '0};
            r_u       <= '{default: '0};
            r_v       <= '{default: '0};
            r_acc     <= '{default: '0};
            r_cnt     <= '0;
            r_m_coeff <= '0;
            r_m_bits  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_s   <= w_s_red;
                        r_u   <= w_u_red;
                        r_v   <= w_v_red;
                        r_acc <= '{default: '0};
                        r_cnt <= '0;
                    end
                end
                S_MAC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_wrap) begin
                        r_acc[w_idx] <= r_acc[w_idx] - w_prod_ext;
                    end else begin
                        r_acc[w_idx] <= r_acc[w_idx] + w_prod_ext;
                    end
                end
                S_REDUCE: begin
                    for (int j = 0; j < N; j++) begin
                        r_m_coeff[j] <= {{(COEFF_W-RED_W){1'b0}}, w_m_red[j]};
                        r_m_bits[j]  <= (w_m_red[j] >= RED_W'(DEC_LO)) &&
                                        (w_m_red[j] <= RED_W'(DEC_HI));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_coeff = r_m_coeff;
    assign m_bits  = r_m_bits;

endmodule : baby_kyber_decrypt
`default_nettype wire
